fifo_rd_arb: RTL

FIFO_RD_ARB -- requirements
Module: fifo_rd_arb

---
 rtl/fifo_rd_arb.sv | 78 +++++++
 1 files changed

// File: rtl/fifo_rd_arb.sv
// fifo_rd_arb: round-robin arbiter granting bounded FIFO read bursts to NREQ requesters
module fifo_rd_arb #(
   parameter int DSIZE = 8,
   parameter int NREQ  = 4,
   parameter int BURST = 4
) (
   input  logic             rclk,
   input  logic             rrst,
   input  logic             rempty,
   input  logic [DSIZE-1:0] rdata,
   output logic             rinc,
   input  logic [NREQ-1:0]  req,
   output logic [NREQ-1:0]  gnt,
   output logic [DSIZE-1:0] dout,
   output logic [NREQ-1:0]  dout_vld,
   output logic             busy
);
   localparam int PW = $clog2(NREQ);
   localparam int BW = $clog2(BURST) + 1;
   typedef enum logic {IDLE, OWN} state_t;
   state_t state, state_nxt;
   logic [PW-1:0] rr_ptr, owner, win;
   logic [BW-1:0] bcnt;
   logic found, release_own;

   // first requester at or above rr_ptr, wrapping past NREQ-1
   always_comb begin
      win = rr_ptr;
      found = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (!found && req[PW'((int'(rr_ptr) + i) % NREQ)]) begin
            win = PW'((int'(rr_ptr) + i) % NREQ);
            found = 1'b1;
         end
      end
   end

   // pop strobe, release condition and next state
   always_comb begin
      rinc = state == OWN && !rempty && req[owner];
      release_own = !req[owner] || (rinc && bcnt == BW'(BURST - 1));
      state_nxt = state == IDLE ? (|req ? OWN : IDLE) : (release_own ? IDLE : OWN);
   end

   assign busy = state == OWN;

   // state register
   always_ff @(posedge rclk or posedge rrst) begin
      if (rrst) state <= IDLE;
      else state <= state_nxt;
   end

   // grant, round-robin pointer, burst count and popped-word registers
   always_ff @(posedge rclk or posedge rrst) begin
      if (rrst) begin
         gnt <= '0;
         owner <= '0;
         rr_ptr <= '0;
         bcnt <= '0;
         dout <= '0;
         dout_vld <= '0;
      end else begin
         dout_vld <= rinc ? gnt : '0;
         if (rinc) dout <= rdata;
         if (state == IDLE && |req) begin
            gnt <= NREQ'(1) << win;
            owner <= win;
            bcnt <= '0;
         end else if (state == OWN && release_own) begin
            gnt <= '0;
            rr_ptr <= owner == PW'(NREQ - 1) ? '0 : owner + 1'b1;
            bcnt <= '0;
         end else if (rinc) begin
            bcnt <= bcnt + 1'b1;
         end
      end
   end
endmodule
